// File: rtl/arith_result_stats.sv
// rtl/arith_result_stats.sv - windowed sum/min/max/count statistics over an arithmetic result stream
module arith_result_stats #(
    parameter int DATA_W = 32,
    parameter int WIN    = 8,
    parameter int SIGNED = 0,
    parameter int SUM_W  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [15:0]       out_count
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              out_valid_q, out_valid_d;
    logic [SUM_W-1:0]  out_sum_q, out_sum_d;
    logic [DATA_W-1:0] out_min_q, out_min_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [15:0]       out_cnt_q, out_cnt_d;

    logic                    in_xfer;
    logic                    out_xfer;
    logic signed [SUM_W-1:0] sample_sext;
    logic [SUM_W-1:0]        sample_ext;

    function automatic logic is_less(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

    assign in_ready    = (state_q == ST_ACCUM);
    assign in_xfer     = in_valid && in_ready;
    assign out_xfer    = out_valid_q && out_ready;
    assign sample_sext = SUM_W'($signed(in_data));
    assign sample_ext  = (SIGNED != 0) ? $unsigned(sample_sext) : SUM_W'(in_data);

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        min_d       = min_q;
        max_d       = max_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        out_cnt_d   = out_cnt_q;

        case (state_q)
            ST_ACCUM: begin
                if (in_xfer) begin
                    sum_d = sum_q + sample_ext;
                    cnt_d = cnt_q + 16'd1;
                    // First sample seeds both extremes; ties never replace the stored value.
                    if (cnt_q == 16'd0) begin
                        min_d = in_data;
                        max_d = in_data;
                    end else begin
                        if (is_less(in_data, min_q)) min_d = in_data;
                        if (is_less(max_q, in_data)) max_d = in_data;
                    end
                end
                if ((in_xfer && cnt_d == 16'(WIN)) || (flush && cnt_d != 16'd0)) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    out_sum_d   = sum_d;
                    out_min_d   = min_d;
                    out_max_d   = max_d;
                    out_cnt_d   = cnt_d;
                end
            end
            default: begin
                if (out_xfer) begin
                    state_d     = ST_ACCUM;
                    out_valid_d = 1'b0;
                    sum_d       = '0;
                    min_d       = '0;
                    max_d       = '0;
                    cnt_d       = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            sum_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            min_q       <= min_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
    assign out_count = out_cnt_q;

endmodule
